sram_w_axi_bridge: RTL

Converts the DCache/MMU write-burst SRAM-like interface (SRAM_W_AXI_i, slave side) into one AXI3 write master: AW, W and B channels. It sits between the DCache write-back/uncached-store path and the SoC AXI crossbar. It supports a single outstanding burst of 1–16 beats. AW and W are issued concurrently.

---
 rtl/sram_w_axi_bridge_pkg.sv | 10 +
 rtl/sram_w_axi_bridge_if.sv | 22 ++
 rtl/sram_w_axi_bridge.sv | 96 +++++++++
 3 files changed

// File: rtl/sram_w_axi_bridge_pkg.sv
// sram_w_axi_bridge_pkg: shared AXI write constants and bridge state type
package sram_w_axi_bridge_pkg;
    localparam logic [3:0] AXI_ID          = 4'd1;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} axi_w_state_t;
endpackage

// File: rtl/sram_w_axi_bridge_if.sv
// sram_w_axi_bridge_if: DCache/MMU write-burst SRAM-like request interface
interface sram_w_axi_bridge_if;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wlast;
    logic        addr_ok;
    logic        data_ok;
    logic        wready;
    modport master (
        output req, addr, len, size, wstrb, wdata, wvalid, wlast,
        input  addr_ok, data_ok, wready
    );
    modport slave (
        input  req, addr, len, size, wstrb, wdata, wvalid, wlast,
        output addr_ok, data_ok, wready
    );
endinterface

// File: rtl/sram_w_axi_bridge.sv
// sram_w_axi_bridge: SRAM-like write burst to single-outstanding AXI3 AW/W/B master
module sram_w_axi_bridge
    import sram_w_axi_bridge_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    sram_w_axi_bridge_if.slave  sram,
    output logic [3:0]          o_awid,
    output logic [31:0]         o_awaddr,
    output logic [3:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [3:0]          o_wid,
    output logic [31:0]         o_wdata,
    output logic [3:0]          o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [3:0]          i_bid,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready,
    output logic                o_bresp_err,
    output logic                o_protocol_err
);
    axi_w_state_t r_state;
    logic         r_aw_done;
    logic         r_w_done;
    logic [3:0]   r_cnt;
    logic [3:0]   r_len;
    logic [2:0]   r_size;
    logic [31:0]  r_addr;
    logic         w_busy;
    logic         w_last;
    logic         w_beat;
    logic         w_aw_done_nx;
    logic         w_w_done_nx;
    logic         w_unused_bid;
    assign w_unused_bid   = ^i_bid;
    assign w_busy         = r_state == BUSY;
    assign w_last         = r_cnt == r_len;
    assign o_awid         = AXI_ID;
    assign o_wid          = AXI_ID;
    assign o_awburst      = AXI_BURST_INCR;
    assign o_awaddr       = r_addr;
    assign o_awlen        = r_len;
    assign o_awsize       = r_size;
    assign o_awvalid      = w_busy && !r_aw_done;
    assign o_wdata        = sram.wdata;
    assign o_wstrb        = sram.wstrb;
    assign o_wvalid       = w_busy && !r_w_done && sram.wvalid;
    assign o_wlast        = w_busy && w_last;
    assign w_beat         = o_wvalid && i_wready;
    assign o_bready       = r_state == RESP;
    assign sram.addr_ok   = r_state == IDLE;
    assign sram.wready    = w_busy && !r_w_done && i_wready;
    assign sram.data_ok   = o_bready && i_bvalid;
    assign o_bresp_err    = sram.data_ok && (i_bresp != AXI_RESP_OKAY);
    assign o_protocol_err = w_beat && (sram.wlast != w_last);
    // Next-cycle flags let a same-cycle AW and final-W completion leave BUSY at once
    assign w_aw_done_nx   = r_aw_done || (o_awvalid && i_awready);
    assign w_w_done_nx    = r_w_done || (w_beat && w_last);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_cnt     <= 4'd0;
            r_len     <= 4'd0;
            r_size    <= 3'd0;
            r_addr    <= 32'd0;
        end else begin
            case (r_state)
                IDLE: if (sram.req) begin
                    r_addr    <= sram.addr;
                    r_len     <= sram.len;
                    r_size    <= sram.size;
                    r_cnt     <= 4'd0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_state   <= BUSY;
                end
                BUSY: begin
                    r_aw_done <= w_aw_done_nx;
                    r_w_done  <= w_w_done_nx;
                    if (w_beat) r_cnt <= r_cnt + 4'd1;
                    if (w_aw_done_nx && w_w_done_nx) r_state <= RESP;
                end
                RESP: if (i_bvalid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
